// File: rtl/crtc6845.sv
// crtc6845: 6845-type CRTC producing HSYNC/VSYNC/DISPEN and MA/RA refresh addresses,
// programmed through an address-register/data-register port pair.
module crtc6845 (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        CCLK_EN,
  input  logic        CS_N,
  input  logic        RS,
  input  logic        R_NW,
  input  logic        WR_EN,
  input  logic [7:0]  DIN,
  output logic [7:0]  DOUT,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DISPEN,
  output logic [13:0] MA,
  output logic [4:0]  RA
);
  typedef enum logic {NORMAL, ADJUST} state_t;
  localparam logic [15:0][7:0] MASK = {8'hFF, 8'h3F, 8'hFF, 8'h3F, 8'h1F, 8'h7F, 8'h1F, 8'h03,
                                       8'h7F, 8'h7F, 8'h1F, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  localparam logic [15:0][7:0] INIT = {8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'd7,  8'h00,
                                       8'd30, 8'd25, 8'd0,  8'd38, 8'h8E, 8'd46, 8'd40, 8'd63};
  logic [15:0][7:0] r_reg;
  logic [4:0]       r_ar;
  logic [7:0]       r_hcc;
  logic [4:0]       r_vlc, r_adj;
  logic [6:0]       r_vcc;
  logic [3:0]       r_hsw, r_vsw;
  logic [13:0]      r_ma_row, r_ma_next;
  logic             r_vde;
  state_t           r_state;
  logic [7:0]  w_r0, w_r1, w_r2, w_r3;
  logic [6:0]  w_r4, w_r6, w_r7;
  logic [4:0]  w_r5, w_r9;
  logic [13:0] w_start;
  logic        w_wr, w_eol, w_last, w_bottom, w_frame, w_enter_adj, w_row, w_rowstart;
  logic        w_vde_n, w_hs_n, w_vs_n;
  logic [7:0]  w_hcc_n;
  logic [4:0]  w_vlc_n, w_adj_n;
  logic [6:0]  w_vcc_n;
  logic [13:0] w_ma_row_n, w_ma_next_n;
  state_t      w_state_n;
  assign w_r0    = r_reg[0];
  assign w_r1    = r_reg[1];
  assign w_r2    = r_reg[2];
  assign w_r3    = r_reg[3];
  assign w_r4    = r_reg[4][6:0];
  assign w_r5    = r_reg[5][4:0];
  assign w_r6    = r_reg[6][6:0];
  assign w_r7    = r_reg[7][6:0];
  assign w_r9    = r_reg[9][4:0];
  assign w_start = {r_reg[12][5:0], r_reg[13]};
  // only R14/R15 (addresses 0b0111x) are readable
  assign DOUT = (!CS_N && R_NW && RS && r_ar[4:1] == 4'b0111) ? r_reg[r_ar[3:0]] : 8'h00;
  assign w_wr = WR_EN && !CS_N && !R_NW;
  assign w_eol       = r_hcc == w_r0;
  assign w_last      = r_vlc == w_r9;
  assign w_bottom    = r_state == NORMAL && w_last && r_vcc == w_r4;
  assign w_frame     = w_eol && (r_state == ADJUST ? r_adj == w_r5 - 5'd1 : w_bottom && w_r5 == 5'd0);
  assign w_enter_adj = w_eol && w_bottom && w_r5 != 5'd0;
  assign w_row       = w_eol && r_state == NORMAL && w_last && r_vcc != w_r4;
  assign w_rowstart  = w_frame || w_row;
  assign w_hcc_n     = w_eol ? 8'd0 : r_hcc + 8'd1;
  assign w_vlc_n     = (w_rowstart || w_enter_adj) ? 5'd0 : w_eol ? r_vlc + 5'd1 : r_vlc;
  assign w_vcc_n     = w_frame ? 7'd0 : w_row ? r_vcc + 7'd1 : r_vcc;
  assign w_adj_n     = w_enter_adj ? 5'd0 : (w_eol && r_state == ADJUST) ? r_adj + 5'd1 : r_adj;
  assign w_state_n   = w_enter_adj ? ADJUST : w_frame ? NORMAL : r_state;
  assign w_ma_row_n  = w_frame ? w_start : w_row ? r_ma_next : r_ma_row;
  assign w_ma_next_n = (r_hcc == w_r1 && w_last) ? r_ma_row + {6'd0, w_r1} : r_ma_next;
  assign w_vde_n     = w_rowstart ? (w_frame || r_vde) && w_vcc_n != w_r6 : r_vde;
  // a running sync ignores its start condition until its width counter expires
  assign w_hs_n = HSYNC ? r_hsw != w_r3[3:0] : w_hcc_n == w_r2 && w_r3[3:0] != 4'd0;
  assign w_vs_n = VSYNC ? !(w_eol && r_vsw == w_r3[7:4]) : w_rowstart && w_vcc_n == w_r7;
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_reg     <= INIT;
      r_ar      <= 5'd0;
      r_hcc     <= INIT[0];
      r_vlc     <= INIT[9][4:0];
      r_vcc     <= INIT[4][6:0];
      r_adj     <= 5'd0;
      r_state   <= NORMAL;
      r_vde     <= 1'b0;
      r_ma_row  <= 14'd0;
      r_ma_next <= 14'd0;
      r_hsw     <= 4'd0;
      r_vsw     <= 4'd0;
      HSYNC     <= 1'b0;
      VSYNC     <= 1'b0;
      DISPEN    <= 1'b0;
      MA        <= 14'd0;
      RA        <= 5'd0;
    end else begin
      if (w_wr && !RS) r_ar <= DIN[4:0];
      if (w_wr && RS && !r_ar[4]) r_reg[r_ar[3:0]] <= DIN & MASK[r_ar[3:0]];
      if (CCLK_EN) begin
        r_hcc     <= w_hcc_n;
        r_vlc     <= w_vlc_n;
        r_vcc     <= w_vcc_n;
        r_adj     <= w_adj_n;
        r_state   <= w_state_n;
        r_vde     <= w_vde_n;
        r_ma_row  <= w_ma_row_n;
        r_ma_next <= w_ma_next_n;
        r_hsw     <= HSYNC ? r_hsw + 4'd1 : 4'd1;
        r_vsw     <= VSYNC ? (w_eol ? r_vsw + 4'd1 : r_vsw) : 4'd1;
        HSYNC     <= w_hs_n;
        VSYNC     <= w_vs_n;
        DISPEN    <= w_hcc_n < w_r1 && w_vde_n && w_state_n == NORMAL;
        MA        <= w_ma_row_n + {6'd0, w_hcc_n};
        RA        <= w_vlc_n;
      end
    end
  end
endmodule

// File: tb/tb_crtc6845.sv
// tb_crtc6845: randomized and directed checks of crtc6845 against a frame-position model
// that derives every output from the tick index within the frame.
module tb_crtc6845;
  logic        clk = 1'b0, RESET_N = 1'b0, CCLK_EN = 1'b0, CS_N = 1'b1, RS = 1'b0, R_NW = 1'b1, WR_EN = 1'b0;
  logic [7:0]  DIN = 8'h00, DOUT;
  logic        HSYNC, VSYNC, DISPEN;
  logic [13:0] MA;
  logic [4:0]  RA;
  logic [21:0] got, exp;
  int n_chk = 0, n_fail = 0;
  int m_r[16];
  int msk[16] = '{255, 255, 255, 255, 127, 31, 127, 127, 3, 31, 127, 31, 63, 255, 63, 255};
  crtc6845 dut (.clk(clk), .RESET_N(RESET_N), .CCLK_EN(CCLK_EN), .CS_N(CS_N), .RS(RS), .R_NW(R_NW),
                .WR_EN(WR_EN), .DIN(DIN), .DOUT(DOUT), .HSYNC(HSYNC), .VSYNC(VSYNC), .DISPEN(DISPEN),
                .MA(MA), .RA(RA));
  always #5 clk = ~clk;
  assign got = {HSYNC, VSYNC, DISPEN, MA, RA};
  function automatic void set_defaults();
    m_r = '{63, 40, 46, 'h8E, 38, 0, 25, 30, 0, 7, 0, 0, 'h30, 0, 0, 0};
  endfunction
  function automatic int flen();
    return ((m_r[4] + 1) * (m_r[9] + 1) + m_r[5]) * (m_r[0] + 1);
  endfunction
  // expected {HSYNC,VSYNC,DISPEN,MA,RA} at tick p of a frame starting at address start
  function automatic logic [21:0] model(input int p, input int start);
    int lp, rl, line, h, hw, vw, row, ra;
    bit adj, hs, vs, de;
    lp = m_r[0] + 1; rl = m_r[9] + 1; line = p / lp; h = p % lp;
    hw = m_r[3] % 16; vw = m_r[3] / 16; if (vw == 0) vw = 16;
    adj = line >= (m_r[4] + 1) * rl;
    row = adj ? m_r[4] : line / rl;
    ra = adj ? line - (m_r[4] + 1) * rl : line % rl;
    hs = hw != 0 && h >= m_r[2] && h < m_r[2] + hw;
    vs = line >= m_r[7] * rl && line < m_r[7] * rl + vw;
    de = h < m_r[1] && row < m_r[6] && !adj;
    return {hs, vs, de, 14'(start + row * m_r[1] + h), 5'(ra)};
  endfunction
  task automatic tick(input int gap);
    CCLK_EN = 1'b1; @(posedge clk); #1 CCLK_EN = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask
  task automatic do_reset();
    RESET_N = 1'b0; CCLK_EN = 1'b0;
    repeat (2) @(posedge clk);
    #1 RESET_N = 1'b1; set_defaults();
  endtask
  task automatic wr(input bit rs, input logic [7:0] d);
    CS_N = 1'b0; R_NW = 1'b0; RS = rs; DIN = d; WR_EN = 1'b1;
    @(posedge clk); #1 WR_EN = 1'b0; CS_N = 1'b1; R_NW = 1'b1;
  endtask
  task automatic wr_reg(input int a, input int d);
    wr(1'b0, 8'(a)); wr(1'b1, 8'(d));
    if (a < 16) m_r[a] = d & msk[a];
  endtask
  task automatic rd(input int a, output logic [7:0] v);
    wr(1'b0, 8'(a)); CS_N = 1'b0; R_NW = 1'b1; RS = 1'b1;
    #1 v = DOUT; CS_N = 1'b1;
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    n_chk++; if (got !== 22'd0 || DOUT !== 8'h00) begin n_fail++; $display("FAIL reset_outputs got=%h dout=%h exp=0", got, DOUT); end
    RESET_N = 1'b1; set_defaults();
    @(posedge clk); #1;
    n_chk++; if (got !== 22'd0) begin n_fail++; $display("FAIL idle_no_enable got=%h exp=0", got); end
    tick(0);
    n_chk++; if (got !== {3'b001, 14'h3000, 5'd0}) begin n_fail++; $display("FAIL first_tick got=%h exp=%h", got, {3'b001, 14'h3000, 5'd0}); end
  endtask
  task automatic test_default_frame();
    int hs_l0 = 0, hs_r0 = -1, hs_r1 = -1, de_cnt = 0, vs_cnt = 0, vs_first = -1, len;
    logic prev_hs = 1'b0;
    logic [13:0] ma39 = 0, ma_r1 = 0, ma_r1r3 = 0;
    logic [4:0] ra_r1r3 = 0;
    do_reset();
    len = flen();
    for (int p = 0; p < len; p++) begin
      tick(0);
      exp = model(p, 'h3000);
      n_chk++; if (got !== exp) begin n_fail++; $display("FAIL default_frame p=%0d got=%h exp=%h", p, got, exp); end
      if (HSYNC && p < 64) hs_l0++;
      if (HSYNC && !prev_hs) begin if (hs_r0 < 0) hs_r0 = p; else if (hs_r1 < 0) hs_r1 = p; end
      prev_hs = HSYNC;
      if (DISPEN) de_cnt++;
      if (VSYNC) begin vs_cnt++; if (vs_first < 0) vs_first = p; end
      if (p == 39) ma39 = MA;
      if (p == 512) ma_r1 = MA;
      if (p == 512 + 3 * 64) begin ma_r1r3 = MA; ra_r1r3 = RA; end
    end
    n_chk++; if (hs_l0 != 14) begin n_fail++; $display("FAIL hsync_width got=%0d exp=14", hs_l0); end
    n_chk++; if (hs_r0 != 46) begin n_fail++; $display("FAIL hsync_start got=%0d exp=46", hs_r0); end
    n_chk++; if (hs_r1 - hs_r0 != 64) begin n_fail++; $display("FAIL line_period got=%0d exp=64", hs_r1 - hs_r0); end
    n_chk++; if (de_cnt != 8000) begin n_fail++; $display("FAIL dispen_count got=%0d exp=8000", de_cnt); end
    n_chk++; if (vs_first != 240 * 64) begin n_fail++; $display("FAIL vsync_start got=%0d exp=%0d", vs_first, 240 * 64); end
    n_chk++; if (vs_cnt != 8 * 64) begin n_fail++; $display("FAIL vsync_width got=%0d exp=%0d", vs_cnt, 8 * 64); end
    n_chk++; if (ma39 !== 14'h3027) begin n_fail++; $display("FAIL ma_char39 got=%h exp=3027", ma39); end
    n_chk++; if (ma_r1 !== 14'h3028) begin n_fail++; $display("FAIL ma_row1 got=%h exp=3028", ma_r1); end
    n_chk++; if ({ma_r1r3, ra_r1r3} !== {14'h3028, 5'd3}) begin n_fail++; $display("FAIL ma_row1_ra3 got=%h/%0d exp=3028/3", ma_r1r3, ra_r1r3); end
    tick(0);
    n_chk++; if (got !== {3'b001, 14'h3000, 5'd0}) begin n_fail++; $display("FAIL frame_wrap_19968 got=%h exp=%h", got, {3'b001, 14'h3000, 5'd0}); end
  endtask
  task automatic test_adjust_vsync16();
    int vs_cnt = 0, vs_first = -1, adj_de = 0, len;
    wr_reg(5, 2); wr_reg(3, 'h0E);
    len = flen();
    for (int p = 1; p < len; p++) begin
      tick(0);
      exp = model(p, 'h3000);
      n_chk++; if (got !== exp) begin n_fail++; $display("FAIL adjust_frame p=%0d got=%h exp=%h", p, got, exp); end
      if (VSYNC) begin vs_cnt++; if (vs_first < 0) vs_first = p; end
      if (DISPEN && p >= 312 * 64) adj_de++;
    end
    n_chk++; if (vs_first != 240 * 64) begin n_fail++; $display("FAIL vsync16_start got=%0d exp=%0d", vs_first, 240 * 64); end
    n_chk++; if (vs_cnt != 16 * 64) begin n_fail++; $display("FAIL vsync16_width got=%0d exp=%0d", vs_cnt, 16 * 64); end
    n_chk++; if (adj_de != 0) begin n_fail++; $display("FAIL adjust_dispen got=%0d exp=0", adj_de); end
    tick(0);
    n_chk++; if (got !== {3'b001, 14'h3000, 5'd0}) begin n_fail++; $display("FAIL frame_wrap_20096 got=%h exp=%h", got, {3'b001, 14'h3000, 5'd0}); end
  endtask
  task automatic test_no_hsync();
    int hs_cnt = 0;
    wr_reg(3, 'h80);
    for (int p = 1; p <= 3 * 64; p++) begin
      tick(0);
      exp = model(p, 'h3000);
      n_chk++; if (got !== exp) begin n_fail++; $display("FAIL no_hsync p=%0d got=%h exp=%h", p, got, exp); end
      if (HSYNC) hs_cnt++;
    end
    n_chk++; if (hs_cnt != 0) begin n_fail++; $display("FAIL hsync_disabled got=%0d exp=0", hs_cnt); end
  endtask
  task automatic test_registers();
    logic [7:0] v;
    int a, d;
    do_reset();
    rd(14, v); n_chk++; if (v !== 8'h00) begin n_fail++; $display("FAIL r14_reset got=%h exp=00", v); end
    wr_reg(14, 'hFF);
    rd(14, v); n_chk++; if (v !== 8'h3F) begin n_fail++; $display("FAIL r14_mask got=%h exp=3F", v); end
    wr_reg(15, 'hA5);
    rd(15, v); n_chk++; if (v !== 8'hA5) begin n_fail++; $display("FAIL r15_rw got=%h exp=A5", v); end
    rd(0, v);  n_chk++; if (v !== 8'h00) begin n_fail++; $display("FAIL r0_read got=%h exp=00", v); end
    rd(16, v); n_chk++; if (v !== 8'h00) begin n_fail++; $display("FAIL r16_read got=%h exp=00", v); end
    wr(1'b0, 8'd14); CS_N = 1'b0; R_NW = 1'b1; RS = 1'b0;
    #1 n_chk++; if (DOUT !== 8'h00) begin n_fail++; $display("FAIL rs0_read got=%h exp=00", DOUT); end
    RS = 1'b1; CS_N = 1'b1;
    #1 n_chk++; if (DOUT !== 8'h00) begin n_fail++; $display("FAIL deselected_read got=%h exp=00", DOUT); end
    R_NW = 1'b0; DIN = 8'h12; WR_EN = 1'b1;
    @(posedge clk); #1 WR_EN = 1'b0; R_NW = 1'b1;
    rd(14, v); n_chk++; if (v !== 8'h3F) begin n_fail++; $display("FAIL cs_gated_write got=%h exp=3F", v); end
    for (int i = 0; i < 8; i++) begin
      a = 14 + $urandom_range(0, 1); d = $urandom_range(0, 255);
      wr_reg(a, d);
      rd(a, v); n_chk++; if (v !== 8'(d & msk[a])) begin n_fail++; $display("FAIL rand_rw r%0d got=%h exp=%h", a, v, d & msk[a]); end
    end
    wr_reg(16, 'h55); wr_reg(20, 'h55); wr_reg(30, 'h55);
    rd(14, v); n_chk++; if (v !== 8'(m_r[14])) begin n_fail++; $display("FAIL ignored_write_r14 got=%h exp=%h", v, m_r[14]); end
    rd(15, v); n_chk++; if (v !== 8'(m_r[15])) begin n_fail++; $display("FAIL ignored_write_r15 got=%h exp=%h", v, m_r[15]); end
    for (int p = 0; p < 128; p++) begin
      tick(0);
      exp = model(p, 'h3000);
      n_chk++; if (got !== exp) begin n_fail++; $display("FAIL ignored_write_timing p=%0d got=%h exp=%h", p, got, exp); end
    end
  endtask
  task automatic test_midframe_reset();
    do_reset();
    for (int p = 0; p <= 10 * 512 + 20; p++) begin
      tick(0);
      exp = model(p, 'h3000);
      n_chk++; if (got !== exp) begin n_fail++; $display("FAIL pre_reset p=%0d got=%h exp=%h", p, got, exp); end
    end
    @(negedge clk); RESET_N = 1'b0;
    #1 n_chk++; if (got !== 22'd0) begin n_fail++; $display("FAIL async_reset got=%h exp=0", got); end
    repeat (2) @(posedge clk);
    #1 RESET_N = 1'b1; set_defaults();
    tick(0);
    n_chk++; if (got !== {3'b001, 14'h3000, 5'd0}) begin n_fail++; $display("FAIL post_reset_tick got=%h exp=%h", got, {3'b001, 14'h3000, 5'd0}); end
  endtask
  task automatic test_random_configs();
    int r0, r1, r2, r3, r4, r5, r6, r7, r9, hw, vw, tot, start, len;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      tick(0);
      n_chk++; if (got !== {3'b001, 14'h3000, 5'd0}) begin n_fail++; $display("FAIL rand_pos0 it=%0d got=%h", it, got); end
      r0 = $urandom_range(8, 24); r1 = $urandom_range(1, r0 - 1);
      hw = $urandom_range(0, 6); r2 = $urandom_range(1, r0 + 1 - (hw > 0 ? hw : 1));
      r9 = $urandom_range(0, 3); r4 = $urandom_range(1, 5); r5 = $urandom_range(0, 3);
      r6 = $urandom_range(1, r4 + 2); r7 = $urandom_range(1, r4);
      tot = (r4 + 1) * (r9 + 1) + r5;
      vw = $urandom_range(1, (tot - r7 * (r9 + 1)) < 16 ? tot - r7 * (r9 + 1) : 16);
      r3 = ((vw == 16 ? 0 : vw) << 4) | hw;
      start = $urandom_range(0, 'h3FFF);
      wr_reg(0, r0); wr_reg(1, r1); wr_reg(2, r2); wr_reg(3, r3); wr_reg(4, r4); wr_reg(5, r5);
      wr_reg(6, r6); wr_reg(7, r7); wr_reg(9, r9); wr_reg(12, start >> 8); wr_reg(13, start & 255);
      len = flen();
      for (int p = 1; p < 2 * len + 5; p++) begin
        tick($urandom_range(0, 1));
        exp = model(p % len, p < len ? 'h3000 : start);
        n_chk++; if (got !== exp) begin n_fail++; $display("FAIL rand_cfg it=%0d p=%0d got=%h exp=%h", it, p, got, exp); end
      end
    end
  endtask
  initial begin
    set_defaults();
    test_reset();
    test_default_frame();
    test_adjust_vsync16();
    test_no_hsync();
    test_registers();
    test_midframe_reset();
    test_random_configs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
